cve2_md_sequencer: RTL and testbench
====================================

CVE2_MD_SEQUENCER -- requirements
Module: cve2_md_sequencer

Interface
REQ-001 SHALL have parameter: EarlyDivZero, 1'b1, divide/remainder by zero completes without iterating.
REQ-002 SHALL have port: clk_i  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: en_i  input  1  start request, sampled only in IDLE.
REQ-005 SHALL have port: kill_i  input  1  abort current operation.
REQ-006 SHALL have port: operator_i  input  2 (md_op_e)  MULL/MULH/DIV/REM.
REQ-007 SHALL have port: signed_mode_i  input  2  bit0 op_a signed, bit1 op_b signed.
REQ-008 SHALL have port: op_a_i  input  32  multiplicand/dividend.
REQ-009 SHALL have port: op_b_i  input  32  multiplier/divisor.
REQ-010 SHALL have port: busy_o  output  1  high in any state other than IDLE.
REQ-011 SHALL have port: valid_o  output  1  single-cycle result-valid pulse.
REQ-012 SHALL have port: result_o  output  32  result, held until the next valid_o.

Function
REQ-013 SHALL implement FSM IDLE -> ITER -> FIX -> IDLE; IDLE -> FIX directly on early divide-by-zero.
REQ-014 SHALL accept an operation when state is IDLE, en_i=1 and kill_i=0. Acceptance latches operator, signed_mode and operands. Later input changes SHALL be ignored until IDLE.
REQ-015 SHALL ignore en_i while busy_o=1; there is no queueing.
REQ-016 SHALL count the ITER state through exactly 32 cycles with a 5-bit down-counter from 31 to 0, then enter FIX.
REQ-017 SHALL assert valid_o only in FIX. For a non-early operation accepted at cycle N, valid_o SHALL be high at cycle N+33 and the block SHALL be IDLE at N+34.
REQ-018 SHALL convert signed operands to 32-bit magnitudes plus sign at acceptance; unsigned operands pass through unchanged.
REQ-019 SHALL multiply by radix-2 shift-add into a 64-bit accumulator. The accumulator SHALL be two's-complement negated in FIX if the operand signs differ.
REQ-020 SHALL return product[31:0] for MULL and product[63:32] for MULH. MULH/MULHSU/MULHU are selected only via signed_mode_i.
REQ-021 SHALL divide by restoring division, one quotient bit per ITER cycle, using a 33-bit trial subtract.
REQ-022 SHALL negate the quotient if the operand signs differ, and negate the remainder if the dividend is negative.
REQ-023 SHALL produce quotient 0xFFFFFFFF and remainder op_a for divisor zero, regardless of signed_mode.
REQ-024 SHALL, when EarlyDivZero=1, go from IDLE to FIX on a divisor-zero DIV/REM, giving valid_o at N+1. When EarlyDivZero=0, the same values SHALL be produced after full iteration.
REQ-025 SHALL produce quotient 0x80000000 and remainder 0 for signed 0x80000000 / 0xFFFFFFFF.
REQ-026 SHALL, on kill_i=1 in any state, go to IDLE on the next edge with no valid_o pulse and result_o unchanged.
REQ-027 SHALL give kill_i priority over en_i when both are high in the same IDLE cycle.
REQ-028 SHALL permit a new acceptance in the cycle following the FIX cycle or the kill cycle.

Reset
REQ-029 SHALL, on rst_i high at any time including mid-operation, immediately force state IDLE, counter 0, accumulators 0, result_o 0, valid_o 0, busy_o 0.
REQ-030 SHALL produce no valid_o pulse for an operation interrupted by reset.

Structure
REQ-031 SHALL use md_op_e from the shared core package.
REQ-032 SHALL have the FSM enum md_seq_state_e (IDLE, ITER, FIX) and the constant MD_ITER_COUNT=32 added to the shared core package.
REQ-033 SHALL instantiate one sub-module, cve2_md_addsub: a 33-bit adder/subtractor shared by the multiply accumulate and the divide trial subtract.

Verification
REQ-034 SHALL cover: MULL, signed 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, valid_o exactly at N+33, busy_o high N+1..N+33.
REQ-035 SHALL cover: MULH, signed 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-036 SHALL cover: DIV signed 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; signed 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-037 SHALL cover: DIV 5 / 0 -> 0xFFFFFFFF with valid_o at N+1 (EarlyDivZero=1) and at N+33 (EarlyDivZero=0); REM 5 / 0 -> 5.
REQ-038 SHALL cover: kill_i in ITER cycle 10 -> no valid_o, busy_o low next cycle, result_o unchanged; an en_i in the following cycle is accepted and completes normally.
REQ-039 SHALL cover: rst_i asserted asynchronously mid-ITER -> all outputs 0 before the next clock edge; en_i held high while busy is ignored, with exactly one valid_o per accepted operation.

Source files
------------

// File: rtl/cve2_md_sequencer_pkg.sv
// Shared core definitions for the iterative multiply/divide sequencer.
// Holds the operator encoding, the FSM states and the iteration count.
package cve2_md_sequencer_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'b00,
        MD_OP_MULH = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_REM  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_ITER,
        MD_FIX
    } md_seq_state_e;

    localparam int unsigned MD_ITER_COUNT = 32;

    function automatic logic [31:0] md_abs(input logic [31:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/cve2_md_addsub.sv
// 33-bit adder/subtractor shared by the multiply accumulate and the
// restoring-division trial subtract.
module cve2_md_addsub (
    input  logic [32:0] a,
    input  logic [32:0] b,
    input  logic        sub,
    output logic [32:0] sum
);

    assign sum = a + (sub ? ~b : b) + {32'b0, sub};

endmodule

// File: rtl/cve2_md_sequencer.sv
// Iterative multiply/divide sequencer: radix-2 shift-add multiply and
// restoring division, one bit per cycle, sign fix-up on the way to FIX.
module cve2_md_sequencer
    import cve2_md_sequencer_pkg::*;
#(
    parameter logic EarlyDivZero = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        kill_i,
    input  md_op_e      operator_i,
    input  logic [1:0]  signed_mode_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o
);

    md_seq_state_e state;
    logic [4:0]    cnt;
    md_op_e        op_q;
    logic          sign_a;
    logic          sign_b;
    logic          div_zero;
    logic [31:0]   opnd;
    logic [63:0]   acc;

    logic          is_mul;
    logic [32:0]   add_a;
    logic [32:0]   add_b;
    logic [32:0]   add_sum;
    logic [63:0]   acc_step;
    logic [63:0]   prod;
    logic [31:0]   quot;
    logic [31:0]   rem;
    logic [31:0]   res_final;

    logic          in_mul;
    logic          in_sign_a;
    logic          in_sign_b;
    logic [31:0]   in_mag_a;
    logic [31:0]   in_mag_b;
    logic          in_div_zero;
    logic          early;

    assign busy_o = (state != MD_IDLE);
    assign is_mul = ~op_q[1];

    // Multiply adds the multiplicand to the upper half; divide subtracts the
    // divisor from the remainder shifted left by one with the next dividend bit.
    assign add_a = is_mul ? {1'b0, acc[63:32]} : acc[63:31];
    assign add_b = {1'b0, opnd};

    cve2_md_addsub u_addsub (
        .a   (add_a),
        .b   (add_b),
        .sub (~is_mul),
        .sum (add_sum)
    );

    always_comb begin
        acc_step = acc;
        if (is_mul) begin
            acc_step = acc[0] ? {add_sum, acc[31:1]} : {1'b0, acc[63:1]};
        end else begin
            acc_step = add_sum[32] ? {acc[62:0], 1'b0} : {add_sum[31:0], acc[30:0], 1'b1};
        end
    end

    // Result is formed from the final iteration step so it is registered on FIX entry.
    always_comb begin
        prod      = (sign_a ^ sign_b) ? -acc_step : acc_step;
        quot      = acc_step[31:0];
        rem       = acc_step[63:32];
        res_final = '0;
        unique case (op_q)
            MD_OP_MULL: res_final = prod[31:0];
            MD_OP_MULH: res_final = prod[63:32];
            MD_OP_DIV:  res_final = div_zero ? '1 : ((sign_a ^ sign_b) ? -quot : quot);
            MD_OP_REM:  res_final = sign_a ? -rem : rem;
            default:    res_final = '0;
        endcase
    end

    assign in_mul      = ~operator_i[1];
    assign in_sign_a   = signed_mode_i[0] & op_a_i[31];
    assign in_sign_b   = signed_mode_i[1] & op_b_i[31];
    assign in_mag_a    = md_abs(op_a_i, in_sign_a);
    assign in_mag_b    = md_abs(op_b_i, in_sign_b);
    assign in_div_zero = (op_b_i == '0);
    assign early       = EarlyDivZero & ~in_mul & in_div_zero;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= MD_IDLE;
            cnt      <= '0;
            op_q     <= MD_OP_MULL;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            valid_o  <= 1'b0;
            result_o <= '0;
        end else begin
            valid_o <= 1'b0;
            if (kill_i) begin
                state <= MD_IDLE;
            end else begin
                unique case (state)
                    MD_IDLE: begin
                        if (en_i) begin
                            op_q     <= operator_i;
                            sign_a   <= in_sign_a;
                            sign_b   <= in_sign_b;
                            div_zero <= in_div_zero;
                            opnd     <= in_mul ? in_mag_a : in_mag_b;
                            acc      <= {32'b0, in_mul ? in_mag_b : in_mag_a};
                            cnt      <= 5'(MD_ITER_COUNT - 1);
                            if (early) begin
                                state    <= MD_FIX;
                                valid_o  <= 1'b1;
                                result_o <= (operator_i == MD_OP_REM) ? op_a_i : '1;
                            end else begin
                                state <= MD_ITER;
                            end
                        end
                    end
                    MD_ITER: begin
                        acc <= acc_step;
                        if (cnt == '0) begin
                            state    <= MD_FIX;
                            valid_o  <= 1'b1;
                            result_o <= res_final;
                        end else begin
                            cnt <= cnt - 5'd1;
                        end
                    end
                    MD_FIX: begin
                        state <= MD_IDLE;
                    end
                    default: begin
                        state <= MD_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cve2_md_sequencer.sv
// Directed bench for cve2_md_sequencer, run with and without early divide-by-zero.
module tb_cve2_md_sequencer;
    import cve2_md_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        kill;
    md_op_e      op;
    logic [1:0]  sm;
    logic [31:0] a;
    logic [31:0] b;

    logic        busy_e, valid_e, busy_n, valid_n;
    logic [31:0] res_e, res_n;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res = '0;

    always #5 clk = ~clk;

    cve2_md_sequencer #(.EarlyDivZero(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .kill_i(kill), .operator_i(op),
        .signed_mode_i(sm), .op_a_i(a), .op_b_i(b),
        .busy_o(busy_e), .valid_o(valid_e), .result_o(res_e)
    );

    cve2_md_sequencer #(.EarlyDivZero(1'b0)) dut_nz (
        .clk_i(clk), .rst_i(rst), .en_i(en), .kill_i(kill), .operator_i(op),
        .signed_mode_i(sm), .op_a_i(a), .op_b_i(b),
        .busy_o(busy_n), .valid_o(valid_n), .result_o(res_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following FIX.
    task automatic run_op(input string tag, input md_op_e o, input logic [1:0] s,
                          input logic [31:0] va, input logic [31:0] vb, input logic [31:0] exp,
                          input int lat_e_exp, input int lat_n_exp, input logic hold);
        int          lat_e = 0, lat_n = 0, cnt_e = 0, cnt_n = 0;
        logic        busy_bad = 1'b0;
        logic [31:0] got_e = '0, got_n = '0;
        op = o; sm = s; a = va; b = vb; en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (hold) begin
                    a  = ~va;
                    b  = ~vb;
                    sm = ~s;
                    op = (o == MD_OP_MULL) ? MD_OP_DIV : MD_OP_MULL;
                end else begin
                    en = 1'b0;
                end
            end
            if (valid_e) begin
                cnt_e++;
                if (lat_e == 0) begin lat_e = k; got_e = res_e; end
            end
            if (valid_n) begin
                cnt_n++;
                if (lat_n == 0) begin lat_n = k; got_n = res_n; end
            end
            if ((lat_e == 0 || lat_e == k) && !busy_e) busy_bad = 1'b1;
            if (lat_e != 0 && lat_n != 0) break;
        end
        @(negedge clk);
        en = 1'b0;
        chk({tag, "_lat"},     32'(lat_e), 32'(lat_e_exp));
        chk({tag, "_lat_nz"},  32'(lat_n), 32'(lat_n_exp));
        chk({tag, "_res"},     got_e, exp);
        chk({tag, "_res_nz"},  got_n, exp);
        chk({tag, "_busy"},    32'(busy_bad), 32'd0);
        chk({tag, "_nvalid"},  32'(cnt_e), 32'd1);
        chk({tag, "_nvalid_nz"}, 32'(cnt_n), 32'd1);
        chk({tag, "_idle"},    32'({busy_e, busy_n, valid_e, valid_n}), 32'd0);
        chk({tag, "_held"},    res_e, exp);
        last_res = exp;
    endtask

    initial begin
        int vcount;
        rst = 1'b1; en = 1'b0; kill = 1'b0; op = MD_OP_MULL; sm = 2'b00; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {busy_e, valid_e, busy_n, valid_n, res_e[27:0]}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("mull_s",   MD_OP_MULL, 2'b11, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 33, 1'b0);
        run_op("mulh_s",   MD_OP_MULH, 2'b11, 32'h80000000, 32'h80000000, 32'h40000000, 33, 33, 1'b0);
        run_op("mulhu",    MD_OP_MULH, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 33, 1'b0);
        run_op("mulhsu",   MD_OP_MULH, 2'b01, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 33, 1'b0);
        run_op("div_s",    MD_OP_DIV,  2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 33, 1'b0);
        run_op("rem_s",    MD_OP_REM,  2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 33, 1'b0);
        run_op("div_ovf",  MD_OP_DIV,  2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 33, 1'b0);
        run_op("rem_ovf",  MD_OP_REM,  2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33, 33, 1'b0);
        run_op("div_z",    MD_OP_DIV,  2'b00, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  33, 1'b0);
        run_op("rem_z",    MD_OP_REM,  2'b00, 32'd5,        32'd0,        32'd5,        1,  33, 1'b0);
        run_op("div_z_s",  MD_OP_DIV,  2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1,  33, 1'b0);
        run_op("rem_z_s",  MD_OP_REM,  2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1,  33, 1'b0);
        run_op("div_hold", MD_OP_DIV,  2'b00, 32'd100,      32'd7,        32'd14,       33, 33, 1'b1);

        // kill wins over en in the same idle cycle
        op = MD_OP_MULL; sm = 2'b00; a = 32'd3; b = 32'd4; en = 1'b1; kill = 1'b1;
        @(negedge clk);
        en = 1'b0; kill = 1'b0;
        chk("kill_prio_busy", 32'({busy_e, busy_n, valid_e, valid_n}), 32'd0);

        // kill in ITER cycle 10
        vcount = 0;
        op = MD_OP_MULL; sm = 2'b00; a = 32'd3; b = 32'd4; en = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) en = 1'b0;
            if (valid_e || valid_n) vcount++;
            if (k == 10) begin
                chk("kill_pre_busy", 32'(busy_e), 32'd1);
                kill = 1'b1;
            end
        end
        kill = 1'b0;
        chk("kill_busy",   32'({busy_e, busy_n}), 32'd0);
        chk("kill_nvalid", 32'(vcount), 32'd0);
        chk("kill_result", res_e, last_res);
        run_op("after_kill", MD_OP_MULL, 2'b00, 32'd3, 32'd4, 32'd12, 33, 33, 1'b0);

        // asynchronous reset mid-ITER
        op = MD_OP_DIV; sm = 2'b00; a = 32'd1000; b = 32'd3; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_ctrl",   32'({busy_e, busy_n, valid_e, valid_n}), 32'd0);
        chk("arst_res",    res_e, 32'd0);
        chk("arst_res_nz", res_n, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        vcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid_e || valid_n) vcount++;
        end
        chk("arst_nvalid", 32'(vcount), 32'd0);
        run_op("after_rst", MD_OP_DIV, 2'b00, 32'd1000, 32'd3, 32'd333, 33, 33, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
